// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, visible-area and start-of-line/frame flags.
// Every output is computed from the next position, so all of them describe the position presented at the same time.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        clk_en,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic        ls_q, ls_d, fs_q, fs_d;
  logic [15:0] fc_q, fc_d;
  logic        x_wrap, y_wrap;
  logic [9:0]  x_nxt, y_nxt;

  // Sync outputs are active low inside their windows.
  function automatic logic h_sync_n(input logic [9:0] x);
    return !((x >= H_SYNC_BEG) && (x < H_SYNC_END));
  endfunction

  function automatic logic v_sync_n(input logic [9:0] y);
    return !((y >= V_SYNC_BEG) && (y < V_SYNC_END));
  endfunction

  function automatic logic visible(input logic [9:0] x, input logic [9:0] y);
    return (x < H_VIS) && (y < V_VIS);
  endfunction

  always_comb begin
    x_wrap  = (x_q == H_LAST);
    y_wrap  = x_wrap && (y_q == V_LAST);
    x_nxt   = x_wrap ? 10'd0 : x_q + 10'd1;
    y_nxt   = y_wrap ? 10'd0 : (x_wrap ? y_q + 10'd1 : y_q);

    x_d     = x_q;
    y_d     = y_q;
    blank_d = blank_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    fc_d    = fc_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;

    if (clk_en) begin
      x_d     = x_nxt;
      y_d     = y_nxt;
      blank_d = visible(x_nxt, y_nxt);
      hs_d    = h_sync_n(x_nxt);
      vs_d    = v_sync_n(y_nxt);
      ls_d    = x_wrap;
      fs_d    = y_wrap;
      fc_d    = y_wrap ? fc_q + 16'd1 : fc_q;
    end
  end

  // Reset parks on the last pixel of the frame so the first enabled edge lands on (0,0) as a new frame.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 16'hFFFF;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a default-size instance for line-level behaviour and a
// shrunken instance (16x12 raster) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, en = 1'b0;
  logic [9:0]  x, y;
  logic        bl, hs, vs, ls, fs;
  logic [15:0] fc;

  logic        rst_s = 1'b1, en_s = 1'b0;
  logic [9:0]  xs, ys;
  logic        bls, hss, vss, lss, fss;
  logic [15:0] fcs;

  vga_timing_gen dut (
    .vga_clk(clk), .reset(rst), .clk_en(en),
    .DrawX(x), .DrawY(y), .blank(bl), .hs(hs), .vs(vs),
    .line_start(ls), .frame_start(fs), .frame_count(fc)
  );

  // Small raster: H 8+2+3+3 = 16 (hs low at x 10..12), V 6+2+2+2 = 12 (vs low at y 8..9).
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .vga_clk(clk), .reset(rst_s), .clk_en(en_s),
    .DrawX(xs), .DrawY(ys), .blank(bls), .hs(hss), .vs(vss),
    .line_start(lss), .frame_start(fss), .frame_count(fcs)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic step(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic step_s(input logic r, input logic e);
    @(negedge clk);
    rst_s = r;
    en_s  = e;
    rst   = 1'b1;
    en    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                         input logic eb, input logic eh, input logic ev,
                         input logic el, input logic ef, input logic [15:0] ec);
    chk({tag, ".x"},  32'(x),  32'(ex));
    chk({tag, ".y"},  32'(y),  32'(ey));
    chk({tag, ".blank"}, 32'(bl), 32'(eb));
    chk({tag, ".hs"}, 32'(hs), 32'(eh));
    chk({tag, ".vs"}, 32'(vs), 32'(ev));
    chk({tag, ".ls"}, 32'(ls), 32'(el));
    chk({tag, ".fs"}, 32'(fs), 32'(ef));
    chk({tag, ".fc"}, 32'(fc), 32'(ec));
  endtask

  typedef struct {
    logic        r, e;
    logic [9:0]  x, y;
    logic        b, h, v, l, f;
    logic [15:0] c;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int hs_cnt, hs_bad, hs_run, hs_max, bl_cnt, bl_bad, ls_cnt, ls_bad;
    int err_s, vs_cnt, vs_bad, fs_cnt, bl_s_cnt;
    logic [9:0]  mx, my;
    logic [15:0] mfc;
    logic        mwrap;

    // ---------------- small raster: two full frames ----------------
    step_s(1'b1, 1'b1);
    step_s(1'b1, 1'b1);
    chk("s_reset.x", 32'(xs), 32'd15);
    chk("s_reset.y", 32'(ys), 32'd11);
    chk("s_reset.fc", 32'(fcs), 32'hFFFF);
    mx = 10'd15; my = 10'd11; mfc = 16'hFFFF;
    err_s = 0; vs_cnt = 0; vs_bad = 0; fs_cnt = 0; bl_s_cnt = 0;
    for (int i = 1; i <= 384; i++) begin
      step_s(1'b0, 1'b1);
      mwrap = (mx == 10'd15) && (my == 10'd11);
      if (mx == 10'd15) my = (my == 10'd11) ? 10'd0 : my + 10'd1;
      mx = (mx == 10'd15) ? 10'd0 : mx + 10'd1;
      if (mwrap) mfc = mfc + 16'd1;
      if (xs !== mx || ys !== my || fcs !== mfc ||
          bls !== (mx < 10'd8 && my < 10'd6) ||
          hss !== !(mx >= 10'd10 && mx <= 10'd12) ||
          vss !== !(my >= 10'd8 && my <= 10'd9) ||
          lss !== (mx == 10'd0) || fss !== mwrap) err_s++;
      if (vss === 1'b0) begin
        vs_cnt++;
        if (ys < 10'd8 || ys > 10'd9) vs_bad++;
      end
      if (fss === 1'b1) begin
        fs_cnt++;
        if (!(i == 1 || i == 193)) err_s++;
      end
      if (bls === 1'b1) bl_s_cnt++;
      if (i == 1)   chk("s_first_fc", 32'(fcs), 32'd0);
      if (i == 193) chk("s_second_fc", 32'(fcs), 32'd1);
    end
    chk("s_trace_errors", 32'(err_s), 32'd0);
    chk("s_vs_low_cycles", 32'(vs_cnt), 32'd64);
    chk("s_vs_low_outside", 32'(vs_bad), 32'd0);
    chk("s_frame_starts", 32'(fs_cnt), 32'd2);
    chk("s_visible_cycles", 32'(bl_s_cnt), 32'd96);

    // ---------------- default raster: reset, release, enable toggling ----------------
    tbl[0] = '{1'b1, 1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    tbl[1] = '{1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    tbl[2] = '{1'b0, 1'b1, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 1'b1, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 10'd1,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[6] = '{1'b0, 1'b1, 10'd2,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[7] = '{1'b0, 1'b1, 10'd3,   10'd0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].r, tbl[i].e);
      chk_all($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].b, tbl[i].h,
              tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].c);
    end

    // Finish line 0, then measure line 1 in full.
    for (int i = 0; i < 797; i++) step(1'b0, 1'b1);
    chk("line1_start.x", 32'(x), 32'd0);
    chk("line1_start.y", 32'(y), 32'd1);
    chk("line1_start.ls", 32'(ls), 32'd1);
    hs_cnt = 0; hs_bad = 0; hs_run = 0; hs_max = 0;
    bl_cnt = 0; bl_bad = 0; ls_cnt = 0; ls_bad = 0;
    for (int i = 1; i <= 800; i++) begin
      step(1'b0, 1'b1);
      if (hs === 1'b0) begin
        hs_cnt++;
        hs_run++;
        if (hs_run > hs_max) hs_max = hs_run;
        if (x < 10'd656 || x > 10'd751) hs_bad++;
      end else begin
        hs_run = 0;
      end
      if (bl === 1'b0) begin
        bl_cnt++;
        if (x < 10'd640) bl_bad++;
      end
      if (ls === 1'b1) begin
        ls_cnt++;
        if (i != 800) ls_bad++;
      end
      if (fs === 1'b1) ls_bad++;
    end
    chk("line_hs_low_cycles", 32'(hs_cnt), 32'd96);
    chk("line_hs_max_run", 32'(hs_max), 32'd96);
    chk("line_hs_outside", 32'(hs_bad), 32'd0);
    chk("line_blank_cycles", 32'(bl_cnt), 32'd160);
    chk("line_blank_outside", 32'(bl_bad), 32'd0);
    chk("line_start_count", 32'(ls_cnt), 32'd1);
    chk("line_pulse_misplaced", 32'(ls_bad), 32'd0);
    chk("line2.x", 32'(x), 32'd0);
    chk("line2.y", 32'(y), 32'd2);

    // Line wrap in the middle of the frame.
    for (int i = 0; i < 7199; i++) step(1'b0, 1'b1);
    chk_all("end_row10", 10'd799, 10'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1);
    chk_all("row11", 10'd0, 10'd11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);

    // Hold with clk_en low in the hsync window.
    for (int i = 0; i < 660; i++) step(1'b0, 1'b1);
    chk_all("hold_pre", 10'd660, 10'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0);
    chk_all("hold", 10'd660, 10'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

    // Reset mid-line, then the post-reset start repeats.
    step(1'b1, 1'b1);
    chk_all("mid_reset", 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF);
    step(1'b0, 1'b1);
    chk_all("restart", 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
